// File: rtl/mmio_pkg.sv
// Shared definitions for the MMIO responder: register offsets, access sizes and
// the byte-lane helpers used by both the load and store paths.
package mmio_pkg;

  localparam logic [4:0] OFF_DUTY   = 5'h00;
  localparam logic [4:0] OFF_MICROS = 5'h04;
  localparam logic [4:0] OFF_MILLIS = 5'h08;
  localparam logic [4:0] OFF_ALARM  = 5'h0C;
  localparam logic [4:0] OFF_STATUS = 5'h10;

  typedef enum logic [2:0] {
    F3_B  = 3'b000,
    F3_H  = 3'b001,
    F3_W  = 3'b010,
    F3_BU = 3'b100,
    F3_HU = 3'b101
  } funct3_e;

  // Halfword accesses ignore addr[0]; word accesses ignore addr[1:0].
  function automatic logic [3:0] byte_en(logic [2:0] funct3, logic [1:0] addr);
    case (funct3)
      F3_B, F3_BU: byte_en = 4'b0001 << addr;
      F3_H, F3_HU: byte_en = addr[1] ? 4'b1100 : 4'b0011;
      default:     byte_en = 4'b1111;
    endcase
  endfunction

  function automatic logic [31:0] store_align(logic [2:0] funct3, logic [31:0] data);
    case (funct3)
      F3_B, F3_BU: store_align = {4{data[7:0]}};
      F3_H, F3_HU: store_align = {2{data[15:0]}};
      default:     store_align = data;
    endcase
  endfunction

  function automatic logic [31:0] apply_be(logic [31:0] old_word, logic [31:0] new_word,
                                           logic [3:0] be);
    apply_be = old_word;
    for (int i = 0; i < 4; i++) begin
      if (be[i]) apply_be[8*i +: 8] = new_word[8*i +: 8];
    end
  endfunction

  function automatic logic [31:0] load_ext(logic [31:0] word, logic [2:0] funct3,
                                           logic [1:0] addr);
    logic [7:0]  b;
    logic [15:0] h;
    b = word[{addr, 3'b000} +: 8];
    h = addr[1] ? word[31:16] : word[15:0];
    case (funct3)
      F3_B:    load_ext = {{24{b[7]}}, b};
      F3_BU:   load_ext = {24'h0, b};
      F3_H:    load_ext = {{16{h[15]}}, h};
      F3_HU:   load_ext = {16'h0, h};
      default: load_ext = word;
    endcase
  endfunction

endpackage

// File: rtl/pwm_channel.sv
// One PWM output. The duty value is captured into a shadow register only at a
// period boundary so a write never produces a truncated or stretched pulse.
module pwm_channel (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       tick,
  input  logic       period_end,
  input  logic [7:0] cnt,
  input  logic [7:0] duty_in,
  output logic       out
);

  logic [7:0] shadow_q, shadow_d;
  logic       out_q, out_d;

  always_comb begin
    shadow_d = (tick && period_end) ? duty_in : shadow_q;
    out_d    = (cnt < shadow_q);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      shadow_q <= '0;
      out_q    <= 1'b0;
    end else begin
      shadow_q <= shadow_d;
      out_q    <= out_d;
    end
  end

  assign out = out_q;

endmodule

// File: rtl/mmio_responder.sv
// Memory-mapped peripheral target: PWM duty registers, free-running us/ms
// timers and a millisecond alarm with a sticky write-1-to-clear flag.
module mmio_responder
  import mmio_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR = 32'hFFFF_FF00,
  parameter int          CLK_HZ    = 12_000_000,
  parameter int          PWM_DIV   = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        write_mem,
  input  logic [2:0]  funct3,
  input  logic [31:0] write_address,
  input  logic [31:0] write_data,
  input  logic [31:0] read_address,
  output logic [31:0] read_data,
  output logic        read_hit,
  output logic        led,
  output logic        red,
  output logic        green,
  output logic        blue
);

  localparam int CLK_PER_US = CLK_HZ / 1_000_000;
  localparam int US_W       = $clog2(CLK_PER_US);
  localparam int DIV_W      = (PWM_DIV > 1) ? $clog2(PWM_DIV) : 1;

  logic [31:0]      duty_q, duty_d, alarm_q, alarm_d;
  logic [31:0]      micros_q, micros_d, millis_q, millis_d;
  logic             flag_q, flag_d;
  logic [US_W-1:0]  us_pre_q, us_pre_d;
  logic [9:0]       ms_sub_q, ms_sub_d;
  logic [DIV_W-1:0] pwm_div_q, pwm_div_d;
  logic [7:0]       pwm_cnt_q, pwm_cnt_d;
  logic [31:0]      read_data_q, read_data_d;
  logic             read_hit_q, read_hit_d;

  logic        w_hit, r_hit, us_tick, ms_tick, pwm_tick, period_end;
  logic [4:0]  w_off, r_off;
  logic [3:0]  be;
  logic [31:0] wdata, r_word;

  // NOTE: every signal written here gets a value before any branch, so no latch is inferred.
  always_comb begin
    w_hit = write_mem && (write_address[31:5] == BASE_ADDR[31:5]);
    r_hit = (read_address[31:5] == BASE_ADDR[31:5]);
    w_off = {write_address[4:2], 2'b00};
    r_off = {read_address[4:2], 2'b00};
    be    = byte_en(funct3, write_address[1:0]);
    wdata = store_align(funct3, write_data);

    us_tick  = (us_pre_q == US_W'(CLK_PER_US - 1));
    ms_tick  = us_tick && (ms_sub_q == 10'd999);
    us_pre_d = us_tick ? '0 : us_pre_q + 1'b1;
    ms_sub_d = ms_sub_q;
    if (us_tick) ms_sub_d = ms_tick ? 10'd0 : ms_sub_q + 10'd1;
    micros_d = micros_q + {31'b0, us_tick};
    millis_d = millis_q + {31'b0, ms_tick};

    duty_d  = duty_q;
    alarm_d = alarm_q;
    flag_d  = flag_q;
    if (w_hit && w_off == OFF_DUTY)  duty_d  = apply_be(duty_q, wdata, be);
    if (w_hit && w_off == OFF_ALARM) alarm_d = apply_be(alarm_q, wdata, be);
    if (w_hit && w_off == OFF_STATUS && be[0] && wdata[0]) flag_d = 1'b0;
    // A match in the same cycle as a clear must not be lost.
    if (ms_tick && (millis_d == alarm_q)) flag_d = 1'b1;

    pwm_tick   = (pwm_div_q == DIV_W'(PWM_DIV - 1));
    period_end = (pwm_cnt_q == 8'hFF);
    pwm_div_d  = pwm_tick ? '0 : pwm_div_q + 1'b1;
    pwm_cnt_d  = pwm_cnt_q + {7'b0, pwm_tick};

    case (r_off)
      OFF_DUTY:   r_word = duty_q;
      OFF_MICROS: r_word = micros_q;
      OFF_MILLIS: r_word = millis_q;
      OFF_ALARM:  r_word = alarm_q;
      OFF_STATUS: r_word = {31'b0, flag_q};
      default:    r_word = '0;
    endcase
    read_hit_d  = r_hit;
    read_data_d = r_hit ? load_ext(r_word, funct3, read_address[1:0]) : '0;
  end

  // NOTE: state updates use non-blocking assignments so all flops see pre-edge values.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      duty_q      <= '0;
      alarm_q     <= 32'hFFFF_FFFF;
      micros_q    <= '0;
      millis_q    <= '0;
      flag_q      <= 1'b0;
      us_pre_q    <= '0;
      ms_sub_q    <= '0;
      pwm_div_q   <= '0;
      pwm_cnt_q   <= '0;
      read_data_q <= '0;
      read_hit_q  <= 1'b0;
    end else begin
      duty_q      <= duty_d;
      alarm_q     <= alarm_d;
      micros_q    <= micros_d;
      millis_q    <= millis_d;
      flag_q      <= flag_d;
      us_pre_q    <= us_pre_d;
      ms_sub_q    <= ms_sub_d;
      pwm_div_q   <= pwm_div_d;
      pwm_cnt_q   <= pwm_cnt_d;
      read_data_q <= read_data_d;
      read_hit_q  <= read_hit_d;
    end
  end

  assign read_data = read_data_q;
  assign read_hit  = read_hit_q;

  pwm_channel u_led (.clk(clk), .rst_n(rst_n), .tick(pwm_tick), .period_end(period_end),
                     .cnt(pwm_cnt_q), .duty_in(duty_q[7:0]),   .out(led));
  pwm_channel u_red (.clk(clk), .rst_n(rst_n), .tick(pwm_tick), .period_end(period_end),
                     .cnt(pwm_cnt_q), .duty_in(duty_q[15:8]),  .out(red));
  pwm_channel u_grn (.clk(clk), .rst_n(rst_n), .tick(pwm_tick), .period_end(period_end),
                     .cnt(pwm_cnt_q), .duty_in(duty_q[23:16]), .out(green));
  pwm_channel u_blu (.clk(clk), .rst_n(rst_n), .tick(pwm_tick), .period_end(period_end),
                     .cnt(pwm_cnt_q), .duty_in(duty_q[31:24]), .out(blue));

endmodule
